sseg_scan_driver: RTL and testbench
===================================

// Module: sseg_scan_driver
// PURPOSE
//  Time-multiplexed 4-digit seven-segment driver that displays the LFSR value (or any
//  16-bit word) produced upstream in `top`. It latches a 16-bit hex value and scans the
//  digits one at a time. It drives active-low segments (sseg) and active-low anodes (an)
//  straight to the board pins, with per-slot ghost-suppression blanking and optional
//  leading-zero blanking.
// PARAMETERS
//  REFRESH_DIV   100000  clocks per digit slot (2 ms at 50 MHz); legal range >= BLANK_CYCLES+2
//  BLANK_CYCLES  1       clocks at the start of each slot with all anodes off (0 = no dead time)
// PORTS
//  clk       in   1   system clock
//  reset     in   1   synchronous, active-high reset
//  data_in   in   16  hex value; digit0 = data_in[3:0] (an[0], rightmost)
//  load      in   1   capture data_in, dp_in and blank_lz on this clk edge
//  dp_in     in   4   decimal point per digit, 1 = lit; dp_in[i] belongs to digit i
//  blank_lz  in   1   1 = suppress leading zero digits
//  sseg      out  8   {dp,g,f,e,d,c,b,a}, active low
//  an        out  4   digit enables, active low, one-hot-low or all-high
// BEHAVIOUR
//  - Reset (reset=1 at edge): presc=0, idx=0, data_r=0, dp_r=0, lz_r=0;
//    an=4'b1111, sseg=8'hFF. All outputs are registered.
//  - Prescaler: presc counts 0..REFRESH_DIV-1. At REFRESH_DIV-1 it wraps to 0 and
//    idx advances idx+1 mod 4 (3->0). A slot begins on the edge where presc becomes 0.
//  - Output register, updated every clk from the state that exists before that edge:
//    - if presc < BLANK_CYCLES: an=4'b1111 and sseg=8'hFF (dead time).
//    - else an = ~(4'b0001<<idx), sseg = {~dp_r[idx], seg(nibble idx)}.
//    - Outputs therefore lag presc/idx by exactly 1 clk.
//  - Hex decode, active-low {g..a}:
//    - 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78
//    - 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E
//    - Example full sseg bytes with dp off: 0 = C0, 8 = 80.
//  - Leading-zero blank (lz_r=1): digit i in {3,2,1} is blanked when nibbles i..3 are all 0.
//    - Digit 0 is never blanked.
//    - A blanked digit has its anode still asserted in its slot and drives sseg=8'hFF.
//    - The dp of a blanked digit is also suppressed.
//  - Load: at an edge with load=1, data_r/dp_r/lz_r take the inputs. The output reflects
//    them from the next edge, so they are visible 2 edges after load is sampled,
//    mid-slot if needed. Scanning is not disturbed: presc and idx keep running.
//  - Simultaneous load and slot wrap: both take effect. The first lit cycle of the new
//    slot uses the new data.
//  - Reset mid-slot or mid-blank: all state returns to reset values on that edge. The
//    outputs are an=1111/sseg=FF on the following edge. Scanning restarts at digit 0 after
//    release. Reset overrides a simultaneous load.
//  - No combinational path from any input to any output.
// TESTING  (bench uses REFRESH_DIV=4, BLANK_CYCLES=1, 20 ns clk)
//  1. Hold reset for 3 clks, release. Required: an=1111, sseg=FF during reset.
//     First lit cycle shows an=1110, sseg=C0 (digit0=0).
//  2. Load 16'h1A8F, dp_in=0, blank_lz=0. Over one scan, each slot has 1 cycle
//     an=1111/sseg=FF, then 3 cycles of:
//     an=1110 sseg=8E; an=1101 sseg=80; an=1011 sseg=88; an=0111 sseg=F9.
//  3. Load 16'h0005, blank_lz=1, dp_in=4'b0100. Digits 3..1 show sseg=FF (dp of digit2
//     suppressed); digit0 shows 92.
//     Then load 16'h0405 (blank_lz stays 1, dp_in stays 4'b0100): digit1 shows C0,
//     digit2 shows 19 with dp lit, i.e. byte 19.
//  4. Pulse load with 16'h0003 on the same edge presc wraps 3->0. The next slot shows
//     1 blank cycle, then the new value for that digit.
//     Also pulse load at presc=2 of digit0: sseg changes 2 edges later within the slot,
//     and an is unchanged.
//  5. Assert reset for 1 clk at presc=2 while idx=2. Required: an=1111/sseg=FF next
//     edge; after release, digit0 is lit first (an=1110) and data shows 0.
//  6. Run 40 full scans with random loads. A checker asserts an is never two-low.
//     It also checks that every slot is exactly 4 clks with exactly 1 all-high cycle,
//     and that idx order is 0,1,2,3,0.

Source files
------------

// File: rtl/sseg_scan_driver.sv
// ============================================================================
// Module   : sseg_scan_driver
// Brief    : 4-digit multiplexed seven-segment driver, active-low segments and
//            anodes, per-slot dead time and optional leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sseg_scan_driver #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] data_in,
    input  logic        load,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [7:0]  sseg,
    output logic [3:0]  an
);

    localparam int PW = $clog2(REFRESH_DIV);

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   data_q, data_d;
    logic [3:0]    dp_q, dp_d;
    logic          lz_q, lz_d;
    logic [3:0]    an_q, an_d;
    logic [7:0]    sseg_q, sseg_d;

    logic          w_dead;
    logic [3:0]    w_nib;
    logic [3:0]    w_lzmask;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    // A zero-length dead time would make the compare constant; keep it out of the netlist.
    generate
        if (BLANK_CYCLES == 0) begin : g_no_dead
            assign w_dead = 1'b0;
        end else begin : g_dead
            assign w_dead = (presc_q < PW'(BLANK_CYCLES));
        end
    endgenerate

    always_comb begin
        case (idx_q)
            2'd0:    w_nib = data_q[3:0];
            2'd1:    w_nib = data_q[7:4];
            2'd2:    w_nib = data_q[11:8];
            default: w_nib = data_q[15:12];
        endcase
    end

    // A digit is a leading zero only if it and every digit above it are zero.
    assign w_lzmask[3] = lz_q & (data_q[15:12] == 4'h0);
    assign w_lzmask[2] = w_lzmask[3] & (data_q[11:8] == 4'h0);
    assign w_lzmask[1] = w_lzmask[2] & (data_q[7:4] == 4'h0);
    assign w_lzmask[0] = 1'b0;

    always_comb begin
        presc_d = presc_q + PW'(1);
        idx_d   = idx_q;
        if (presc_q == PW'(REFRESH_DIV - 1)) begin
            presc_d = '0;
            idx_d   = idx_q + 2'd1;
        end
        data_d = data_q;
        dp_d   = dp_q;
        lz_d   = lz_q;
        if (load) begin
            data_d = data_in;
            dp_d   = dp_in;
            lz_d   = blank_lz;
        end
    end

    always_comb begin
        an_d   = 4'b1111;
        sseg_d = 8'hFF;
        if (!w_dead) begin
            an_d = ~(4'b0001 << idx_q);
            if (!w_lzmask[idx_q]) begin
                sseg_d = {~dp_q[idx_q], seg7(w_nib)};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            idx_q   <= 2'd0;
            data_q  <= 16'h0000;
            dp_q    <= 4'h0;
            lz_q    <= 1'b0;
            an_q    <= 4'b1111;
            sseg_q  <= 8'hFF;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            dp_q    <= dp_d;
            lz_q    <= lz_d;
            an_q    <= an_d;
            sseg_q  <= sseg_d;
        end
    end

    assign an   = an_q;
    assign sseg = sseg_q;

endmodule

`default_nettype wire

// File: tb/tb_sseg_scan_driver.sv
// ============================================================================
// Module   : tb_sseg_scan_driver
// Brief    : Directed self-checking bench for sseg_scan_driver (REFRESH_DIV=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sseg_scan_driver;

    logic        clk;
    logic        reset;
    logic [15:0] data_in;
    logic        load;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [7:0]  sseg;
    logic [3:0]  an;

    int n_vec;
    int n_err;
    int cyc;

    sseg_scan_driver #(
        .REFRESH_DIV (4),
        .BLANK_CYCLES(1)
    ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .data_in (data_in),
        .load    (load),
        .dp_in   (dp_in),
        .blank_lz(blank_lz),
        .sseg    (sseg),
        .an      (an)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check_vec(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got an/sseg=%h expected %h", tag, $time, got, exp);
        end
    endtask

    // Outputs are sampled 1 ns after the edge; cyc counts edges since reset release.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Advance until the next edge is the first edge of a digit-0 slot.
    task automatic align();
        while (cyc % 16 != 0) tick();
    endtask

    task automatic run_scan(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] e [4];
        logic [3:0] a;
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int d = 0; d < 4; d++) begin
            for (int p = 0; p < 4; p++) begin
                tick();
                a = ~(4'b0001 << d);
                if (p == 0) check_vec({tag, "_dead"}, {an, sseg}, {4'hF, 8'hFF});
                else        check_vec(tag, {an, sseg}, {a, e[d]});
            end
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic lz);
        data_in  = d;
        dp_in    = dp;
        blank_lz = lz;
        load     = 1'b1;
        tick();
        load     = 1'b0;
        tick();
    endtask

    initial begin
        int p;
        int d;
        logic [3:0] a;
        n_vec    = 0;
        n_err    = 0;
        cyc      = 0;
        reset    = 1'b1;
        load     = 1'b0;
        data_in  = 16'h0000;
        dp_in    = 4'h0;
        blank_lz = 1'b0;

        // Reset held for three clocks, then first slot shows dead cycle and digit0 = 0
        repeat (3) begin
            tick();
            check_vec("reset", {an, sseg}, {4'hF, 8'hFF});
        end
        reset = 1'b0;
        cyc   = 0;
        tick();
        check_vec("first_dead", {an, sseg}, {4'hF, 8'hFF});
        tick();
        check_vec("first_lit", {an, sseg}, {4'hE, 8'hC0});

        // Plain hex scan
        do_load(16'h1A8F, 4'h0, 1'b0);
        align();
        run_scan("hex1A8F", 8'h8E, 8'h80, 8'h88, 8'hF9);

        // Leading-zero blanking, dp on a blanked digit suppressed
        do_load(16'h0005, 4'b0100, 1'b1);
        align();
        run_scan("lz0005", 8'h92, 8'hFF, 8'hFF, 8'hFF);
        do_load(16'h0405, 4'b0100, 1'b1);
        align();
        run_scan("lz0405", 8'h92, 8'hC0, 8'h19, 8'hFF);

        // Load on the slot-wrap edge (digit1 -> digit2)
        align();
        repeat (7) tick();
        data_in  = 16'h0003;
        dp_in    = 4'h0;
        blank_lz = 1'b0;
        load     = 1'b1;
        tick();
        load     = 1'b0;
        check_vec("wrap_old", {an, sseg}, {4'b1101, 8'hC0});
        tick();
        check_vec("wrap_dead", {an, sseg}, {4'hF, 8'hFF});
        tick();
        check_vec("wrap_new", {an, sseg}, {4'b1011, 8'hC0});

        // Mid-slot load at presc=2 of digit0
        align();
        tick();
        tick();
        check_vec("mid_before", {an, sseg}, {4'b1110, 8'hB0});
        data_in = 16'h0007;
        load    = 1'b1;
        tick();
        load    = 1'b0;
        check_vec("mid_edge", {an, sseg}, {4'b1110, 8'hB0});
        tick();
        check_vec("mid_after", {an, sseg}, {4'b1110, 8'hF8});

        // One-clock reset at presc=2 of digit2
        align();
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cyc   = 0;
        check_vec("rst_mid", {an, sseg}, {4'hF, 8'hFF});
        tick();
        check_vec("rst_next", {an, sseg}, {4'hF, 8'hFF});
        tick();
        check_vec("rst_digit0", {an, sseg}, {4'b1110, 8'hC0});

        // 40 scans with random loads: anode sequence and slot structure only
        align();
        repeat (640) begin
            load     = ($urandom_range(0, 7) == 0);
            data_in  = 16'($urandom);
            dp_in    = 4'($urandom);
            blank_lz = 1'($urandom);
            tick();
            p = (cyc - 1) % 4;
            d = ((cyc - 1) / 4) % 4;
            a = ~(4'b0001 << d);
            check_vec("an_onehot", {11'd0, ($countones(~an) <= 1)}, 12'd1);
            if (p == 0) check_vec("rnd_dead", {an, sseg}, {4'hF, 8'hFF});
            else        check_vec("rnd_an", {an, 8'h00}, {a, 8'h00});
        end
        load = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
